graphite_cmd_queue: RTL
=======================

// Module: graphite_cmd_queue
// PURPOSE
//  Buffers 32-bit Graphite command words written by the CPU (IO word address 8) and streams them
//  to the Graphite AXI-stream command slave. Sits directly upstream of graphite: replaces the
//  single-word tvalid pulse register, so the CPU posts bursts without polling tready per word.
//  Status (level/full/overflow) is muxed into the IO read bus by the SoC top.
// PARAMETERS
//  DEPTH        16  words of storage incl. output register; power of two, >= 4
//  AFULL_LEVEL  12  almost_full_o asserts when level_o >= AFULL_LEVEL; 1..DEPTH
//  LW           $clog2(DEPTH+1)  level_o width (localparam, derived)
// PORTS
//  clk                 in   1   system clock (CPU clock domain)
//  reset_i             in   1   synchronous reset, active high
//  ce_i                in   1   clock enable; all state advances only when 1
//  wr_i                in   1   CPU write strobe (wr & ioenb & iowadr==8, already CE-qualified)
//  wr_data_i           in   32  command word
//  cmd_axis_tvalid_o   out  1   AXIS valid to graphite
//  cmd_axis_tready_i   in   1   AXIS ready from graphite
//  cmd_axis_tdata_o    out  32  AXIS data to graphite
//  level_o             out  LW  words accepted, not yet transferred (0..DEPTH)
//  empty_o             out  1   level_o == 0
//  full_o              out  1   level_o == DEPTH
//  almost_full_o       out  1   level_o >= AFULL_LEVEL
//  overflow_o          out  1   sticky: a write was dropped
//  clr_overflow_i      in   1   clears overflow_o (CPU write to status address)
//  words_sent_o        out  32  stats counter (see CONFIGURATION)
// BEHAVIOUR
//  - One clock, synchronous active-high reset; ce_i=0 freezes all state (outputs hold values).
//  - Reset (incl. mid-burst): all queued words discarded; tvalid=0, tdata=0, level=0, empty=1,
//    full=0, almost_full=0, overflow=0, words_sent=0. A pending AXIS beat is abandoned.
//  - Structure: circular RAM of DEPTH-1 entries (rd/wr pointers, wrap at DEPTH-1) + output
//    register holding the head word. tvalid_o/tdata_o are driven only from registers.
//  - Transfer: beat completes in a cycle with ce_i & tvalid_o & tready_i. tdata_o stable while
//    tvalid_o & !tready_i; tvalid_o never drops without a completed beat (except reset).
//  - Output refill: on transfer or when output register is empty, it loads the RAM head if RAM
//    non-empty, else the incoming write word directly (bypass), else tvalid_o <= 0.
//  - Latency: write in cycle N to empty queue -> tvalid_o=1, tdata_o=word at N+1. Back-to-back
//    beats at 1 word/cycle while tready_i held high.
//  - Write acceptance: accepted iff ce_i & wr_i & !full_o (full evaluated at start of cycle).
//    Write while full is dropped and sets overflow_o next cycle, even if a beat completes in
//    the same cycle. Order preserved strictly FIFO.
//  - level_o: +1 on accepted write, -1 on transfer, unchanged when both occur; flags derived
//    combinationally from registered level.
//  - clr_overflow_i and a dropped write in same cycle: overflow_o stays 1 (set wins).
//  - wr_i while reset_i=1 is ignored.
// CONFIGURATION
//  GRAPHITE_CMDQ_STATS_EN defined: words_sent_o counts completed AXIS beats, wraps 2^32-1 -> 0,
//    cleared by reset only.
//  GRAPHITE_CMDQ_STATS_EN undefined: counter not built; words_sent_o tied to 32'd0.
// TESTING
//  - Reset, tready=1, write 0xA5A5_0001 -> next cycle tvalid=1, tdata=0xA5A5_0001; after beat
//    tvalid=0, level=0, empty=1.
//  - tready=0, write 16 words 0..15 -> level=16, full=1, almost_full from 12th write; 17th
//    write 0xDEAD dropped, overflow=1; tready=1 -> drains 0..15 in order, 16 cycles, no 0xDEAD.
//  - tready toggled pseudo-randomly, 200 random words written when !full -> output sequence
//    equals input; tdata never changes while tvalid&!tready; level matches scoreboard.
//  - full queue, write + transfer same cycle -> write dropped, overflow=1, level=15;
//    clr_overflow_i pulse with no drop -> overflow=0.
//  - 5 words queued, tready=0, assert reset_i one cycle -> tvalid=0, level=0; then write 0x7
//    -> only 0x7 emitted.
//  - ce_i=0 with wr_i=1 and tready=1 for 3 cycles -> no level/pointer/tvalid change;
//    STATS_EN build: 40 beats -> words_sent_o=40; without macro -> words_sent_o=0.

Source files
------------

// File: rtl/graphite_cmd_queue.sv
// graphite_cmd_queue: command FIFO between the CPU IO write port and the Graphite
// AXI-stream command slave. The CPU can post bursts without polling tready for each word.
// Storage is a circular RAM of DEPTH-1 words plus an output register that holds the head word.
// Build option: GRAPHITE_CMDQ_STATS_EN builds the completed-beat counter on words_sent_o.
// Ports:
//   clk, reset_i          clock and synchronous active-high reset
//   ce_i                  clock enable; all state holds while it is low
//   wr_i, wr_data_i       CPU write strobe and 32-bit command word
//   cmd_axis_t*           AXI-stream master to Graphite (valid/data registered)
//   level_o               words accepted but not yet transferred (0..DEPTH)
//   empty_o, full_o, almost_full_o   flags decoded from level_o
//   overflow_o            sticky drop flag, cleared by clr_overflow_i
//   words_sent_o          completed-beat counter (0 when the stats option is off)
module graphite_cmd_queue #(
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned AFULL_LEVEL = 12,
  localparam int unsigned LW         = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset_i,
  input  logic          ce_i,
  input  logic          wr_i,
  input  logic [31:0]   wr_data_i,
  output logic          cmd_axis_tvalid_o,
  input  logic          cmd_axis_tready_i,
  output logic [31:0]   cmd_axis_tdata_o,
  output logic [LW-1:0] level_o,
  output logic          empty_o,
  output logic          full_o,
  output logic          almost_full_o,
  output logic          overflow_o,
  input  logic          clr_overflow_i,
  output logic [31:0]   words_sent_o
);

  localparam int unsigned RAM_DEPTH = DEPTH - 1;
  localparam int unsigned PW        = $clog2(RAM_DEPTH);

  logic [31:0]   r_ram [RAM_DEPTH];
  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] r_wr_ptr;
  logic [LW-1:0] r_ram_cnt;
  logic [LW-1:0] r_level;
  logic          r_tvalid;
  logic [31:0]   r_tdata;
  logic          r_overflow;

  logic          w_full;
  logic          w_beat;
  logic          w_wr_ok;
  logic          w_out_load;
  logic          w_ram_nonempty;
  logic          w_pop;
  logic          w_bypass;
  logic          w_push;
  logic [PW-1:0] w_rd_next;
  logic [PW-1:0] w_wr_next;

  // Handshake and write-acceptance decode; full is taken from the registered level.
  assign w_full         = (r_level == LW'(DEPTH));
  assign w_beat         = ce_i & r_tvalid & cmd_axis_tready_i;
  assign w_wr_ok        = ce_i & ~reset_i & wr_i & ~w_full;
  // Output register reloads when its word leaves or when it holds nothing.
  assign w_out_load     = ce_i & (~r_tvalid | cmd_axis_tready_i);
  assign w_ram_nonempty = (r_ram_cnt != '0);
  assign w_pop          = w_out_load & w_ram_nonempty;
  // An empty RAM lets the incoming word go straight to the output register.
  assign w_bypass       = w_out_load & ~w_ram_nonempty & w_wr_ok;
  assign w_push         = w_wr_ok & ~w_bypass;

  // RAM holds DEPTH-1 words, so pointers wrap explicitly rather than by overflow.
  assign w_rd_next = (r_rd_ptr == PW'(RAM_DEPTH - 1)) ? '0 : r_rd_ptr + PW'(1);
  assign w_wr_next = (r_wr_ptr == PW'(RAM_DEPTH - 1)) ? '0 : r_wr_ptr + PW'(1);

  // Storage array; contents need no reset because the pointers define validity.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_ram[r_wr_ptr] <= wr_data_i;
    end
  end

  // Pointers, output register, level and overflow state.
  always_ff @(posedge clk) begin
    if (reset_i) begin
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_ram_cnt  <= '0;
      r_level    <= '0;
      r_tvalid   <= 1'b0;
      r_tdata    <= '0;
      r_overflow <= 1'b0;
    end else if (ce_i) begin
      if (w_pop) begin
        r_rd_ptr <= w_rd_next;
      end
      if (w_push) begin
        r_wr_ptr <= w_wr_next;
      end
      if (w_push && !w_pop) begin
        r_ram_cnt <= r_ram_cnt + LW'(1);
      end else if (w_pop && !w_push) begin
        r_ram_cnt <= r_ram_cnt - LW'(1);
      end

      if (w_out_load) begin
        if (w_ram_nonempty) begin
          r_tvalid <= 1'b1;
          r_tdata  <= r_ram[r_rd_ptr];
        end else if (w_wr_ok) begin
          r_tvalid <= 1'b1;
          r_tdata  <= wr_data_i;
        end else begin
          r_tvalid <= 1'b0;
        end
      end

      if (w_wr_ok && !w_beat) begin
        r_level <= r_level + LW'(1);
      end else if (w_beat && !w_wr_ok) begin
        r_level <= r_level - LW'(1);
      end

      // A dropped write takes priority over a clear in the same cycle.
      if (wr_i && w_full) begin
        r_overflow <= 1'b1;
      end else if (clr_overflow_i) begin
        r_overflow <= 1'b0;
      end
    end
  end

`ifdef GRAPHITE_CMDQ_STATS_EN
  logic [31:0] r_words_sent;

  // Completed-beat counter, wraps naturally at 2^32.
  always_ff @(posedge clk) begin
    if (reset_i) begin
      r_words_sent <= '0;
    end else if (w_beat) begin
      r_words_sent <= r_words_sent + 32'd1;
    end
  end

  assign words_sent_o = r_words_sent;
`else
  assign words_sent_o = 32'd0;
`endif

  assign cmd_axis_tvalid_o = r_tvalid;
  assign cmd_axis_tdata_o  = r_tdata;
  assign level_o           = r_level;
  assign overflow_o        = r_overflow;
  assign empty_o           = (r_level == '0);
  assign full_o            = w_full;
  assign almost_full_o     = (r_level >= LW'(AFULL_LEVEL));

endmodule
